pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it decides per-stage enable and flush, PC enable, bubble insertion for load-use hazards, freeze during data-memory waits, squash on taken branches and jumps, and the terminal halt. It also keeps cycle, stall and flush performance counters.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- ex_dREN  in  1  instruction in EX is a load.
- ex_wsel  in  5  destination register of the instruction in EX.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- mem_dREN, mem_dWEN  in  1 each  instruction in MEM performs a data read or write.
- mem_redirect  in  1  taken branch, j, jal or JR resolved in MEM.
- wb_halt  in  1  halt instruction is in WB.
- pc_en  out  1  PC loads its next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register captures its inputs.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  stage register loads its zero or bubble value; overrides en.
- halted  out  1  core stopped.
- cycle_cnt, stall_cnt, flush_cnt  out  32 each  performance counters.

## Operation
- States: RUN, DWAIT, HALTED. 2-bit state register. Reset state is RUN.
- Outputs are Mealy, combinational from state plus inputs. Default in RUN: pc_en and all en are 1, all flush are 0.
- The rules below are listed in priority order. The first one that matches decides the outputs.
- 1. State is HALTED:
  - All en and pc_en are 0. All flush are 0. halted is 1.
  - The state holds until reset.
- 2. wb_halt is 1 (in RUN or DWAIT):
  - All en and pc_en are 0.
  - Next state is HALTED.
- 3. Data wait: (mem_dREN | mem_dWEN) and dhit is 0.
  - pc_en, ifid_en, idex_en and exmem_en are 0.
  - memwb_flush is 1, so WB gets a bubble and never writes twice.
  - Next state is DWAIT. DWAIT keeps this rule active until dhit is 1.
  - The cycle dhit is 1, the pipeline advances normally and the next state is RUN.
- 4. Redirect: mem_redirect is 1.
  - ifid_flush, idex_flush and exmem_flush are 1.
  - pc_en and memwb_en are 1, so the PC loads the target and the branch retires.
  - An ihit of 0 is ignored this cycle because the fetch is abandoned.
- 5. Load-use hazard: ex_dREN is 1 and ex_wsel is not 0, and ex_wsel equals id_rs, or id_uses_rt is 1 and ex_wsel equals id_rt.
  - pc_en and ifid_en are 0. idex_flush is 1.
  - exmem_en and memwb_en are 1.
  - Exactly one bubble is inserted, because the load moves to MEM on the next cycle.
- 6. Fetch wait: ihit is 0.
  - pc_en is 0. ifid_flush is 1.
  - The other stages advance.
- Register 0 never creates a hazard.
- Counters reset to 0, wrap modulo 2^32, and freeze while halted is 1.
  - cycle_cnt increments every non-halted cycle.
  - stall_cnt increments on cycles where rule 3, 5 or 6 applies.
  - flush_cnt increments on cycles where rule 4 applies.
  - On the wb_halt cycle, cycle_cnt increments and no other counter does.

## Timing
- Reset values: state RUN, halted 0, cycle_cnt, stall_cnt and flush_cnt all 0.
- Control outputs depend on inputs in the same cycle, with zero-cycle latency. They take effect at the next rising edge.
- halted goes to 1 on the edge after wb_halt is sampled.
- Counters update on the same edge that applies the decision.
- If nRST is asserted mid-operation, including in DWAIT or HALTED, the block returns to RUN and clears the counters immediately (asynchronous).
- Simultaneous events resolve by rule priority:
  - Data wait with redirect: the freeze wins. The redirect is re-evaluated once dhit arrives.
  - Load-use with fetch wait: the load-use outputs apply.

## Test plan
- Reset, then ihit is 1 with no hazards for 10 cycles -> all en and pc_en are 1, all flush are 0, cycle_cnt is 10, stall_cnt is 0.
- ex_dREN is 1, ex_wsel is 5, id_rs is 5 for one cycle -> pc_en is 0, ifid_en is 0, idex_flush is 1. Next cycle with ex_dREN at 0: all en are 1. stall_cnt is 1.
- mem_dREN is 1 with dhit 0 for 3 cycles, then dhit is 1 -> 3 frozen cycles with memwb_flush at 1 and the state in DWAIT, then an advance and the state back in RUN. stall_cnt is 3.
- mem_redirect is 1 together with ihit 0 -> ifid_flush, idex_flush and exmem_flush are 1, pc_en is 1, flush_cnt is 1.
- ex_wsel is 0 and id_rs is 0 with ex_dREN 1 -> no stall.
- wb_halt pulses for 1 cycle -> halted is 1 from the next edge on, all en stay 0 for 20 cycles, and counters are frozen. Asserting nRST returns the block to RUN with halted 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage enable/flush, PC enable, hazard
// bubbles, data-wait freeze, redirect squash, halt, and performance counters.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_redirect,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        stall_ev, flush_ev;
    logic        data_wait, load_use;
    logic [31:0] cycle_cnt_reg, stall_cnt_reg, flush_cnt_reg;

    // DWAIT keeps the freeze asserted until dhit, even if the MEM request drops.
    assign data_wait = ((mem_dREN | mem_dWEN) | (state_reg == DWAIT)) & ~dhit;
    assign load_use  = ex_dREN && (ex_wsel != 5'd0) &&
                       ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        state_next  = RUN;

        if (state_reg == HALTED) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            halted     = 1'b1;
            state_next = HALTED;
        end else if (wb_halt) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            state_next = HALTED;
        end else if (data_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            stall_ev    = 1'b1;
            state_next  = DWAIT;
        end else if (mem_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_ev    = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_ev   = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            stall_ev   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= RUN;
            cycle_cnt_reg <= 32'd0;
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg != HALTED) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
                if (stall_ev)
                    stall_cnt_reg <= stall_cnt_reg + 32'd1;
                if (flush_ev)
                    flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; control vector order is
// {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, ex_dREN, id_uses_rt;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        mem_dREN, mem_dWEN, mem_redirect, wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [8:0]  ctrl_vec;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_cycle = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    localparam logic [8:0] V_RUN   = 9'b1_1111_0000;
    localparam logic [8:0] V_LU    = 9'b0_0111_0100;
    localparam logic [8:0] V_DWAIT = 9'b0_0001_0001;
    localparam logic [8:0] V_REDIR = 9'b1_1111_1110;
    localparam logic [8:0] V_IWAIT = 9'b0_1111_1000;
    localparam logic [8:0] V_STOP  = 9'b0_0000_0000;

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ex_dREN(ex_dREN),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect),
        .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .halted(halted), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; ex_dREN = 1'b0; ex_wsel = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; mem_dREN = 1'b0;
        mem_dWEN = 1'b0; mem_redirect = 1'b0; wb_halt = 1'b0;
    endtask

    // Check combinational outputs, then let one rising edge apply them.
    task automatic cyc(input string tag, input logic [8:0] exp_ctrl,
                       input bit counted, input bit s, input bit f);
        #1;
        chk(tag, {23'd0, ctrl_vec}, {23'd0, exp_ctrl});
        @(negedge CLK);
        if (counted) begin
            exp_cycle++;
            if (s) exp_stall++;
            if (f) exp_flush++;
        end
    endtask

    task automatic cnt_chk(input string tag);
        chk({tag, ".cycle"}, cycle_cnt, exp_cycle);
        chk({tag, ".stall"}, stall_cnt, exp_stall);
        chk({tag, ".flush"}, flush_cnt, exp_flush);
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        #1;
        chk("reset.halted", {31'd0, halted}, 32'd0);
        chk("reset.state", {30'd0, dut.state_reg}, 32'd0);
        cnt_chk("reset");
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 10; i++) cyc("run", V_RUN, 1, 0, 0);
        cnt_chk("run10");

        ex_dREN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
        cyc("loaduse.rs", V_LU, 1, 1, 0);
        ex_dREN = 1'b0;
        cyc("loaduse.after", V_RUN, 1, 0, 0);
        chk("loaduse.stall", stall_cnt, 32'd1);
        idle();
        ex_dREN = 1'b1; ex_wsel = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        cyc("loaduse.rt", V_LU, 1, 1, 0);
        id_uses_rt = 1'b0;
        cyc("loaduse.rt_unused", V_RUN, 1, 0, 0);
        idle();

        mem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("dwait.freeze", V_DWAIT, 1, 1, 0);
            chk("dwait.state", {30'd0, dut.state_reg}, 32'd1);
        end
        dhit = 1'b1;
        cyc("dwait.release", V_RUN, 1, 0, 0);
        chk("dwait.state_run", {30'd0, dut.state_reg}, 32'd0);
        idle();
        cnt_chk("dwait");

        mem_dWEN = 1'b1; mem_redirect = 1'b1;
        cyc("dwait_redir.freeze", V_DWAIT, 1, 1, 0);
        dhit = 1'b1;
        cyc("dwait_redir.redir", V_REDIR, 1, 0, 1);
        idle();

        mem_redirect = 1'b1; ihit = 1'b0;
        cyc("redir.ihit0", V_REDIR, 1, 0, 1);
        idle();
        cnt_chk("redir");

        ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        cyc("r0.nohazard", V_RUN, 1, 0, 0);
        ex_wsel = 5'd9; id_rs = 5'd9; ihit = 1'b0;
        cyc("loaduse.iwait", V_LU, 1, 1, 0);
        idle();
        ihit = 1'b0;
        cyc("iwait", V_IWAIT, 1, 1, 0);
        idle();
        cnt_chk("mix");

        wb_halt = 1'b1; mem_dREN = 1'b1;
        #1;
        chk("halt.halted_pre", {31'd0, halted}, 32'd0);
        cyc("halt.cycle", V_STOP, 1, 0, 0);
        idle();
        mem_redirect = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc("halted.ctrl", V_STOP, 0, 0, 0);
            chk("halted.flag", {31'd0, halted}, 32'd1);
        end
        cnt_chk("halted");

        nRST = 1'b0;
        #1;
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.state", {30'd0, dut.state_reg}, 32'd0);
        exp_cycle = 0; exp_stall = 0; exp_flush = 0;
        cnt_chk("rst");
        idle();
        @(negedge CLK);
        nRST = 1'b1;
        cyc("rst.run", V_RUN, 1, 0, 0);
        cnt_chk("rst.run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
